// File: rtl/ahbl_sram_slave.sv
// AHB-Lite subordinate in front of a word-organised SRAM array.
// Byte/halfword/word transfers, fixed wait states per OKAY beat, two-cycle ERROR.
module ahbl_sram_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic                  hmastlock,
  input  logic [31:0]           hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [31:0]           hrdata
);
  localparam int IW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  // one extra index bit so the first word past the array is caught as out of range
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] LIM     = CW'(MEM_WORDS);
  localparam logic [3:0]    WS_LAST = 4'(WAIT_STATES - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t           r_state, w_nxt;
  logic [IW-1:0]    r_idx;
  logic [1:0]       r_off;
  logic [1:0]       r_size;
  logic             r_write;
  logic [3:0]       r_cnt;
  logic [31:0]      r_mem [MEM_WORDS];

  logic             w_rdy, w_acc, w_err, w_we;
  logic [3:0]       w_be;
  logic             w_unused;

  assign w_unused = ^{hburst, hprot, hmastlock, haddr};

  assign w_rdy = !(r_state == S_WAIT || r_state == S_ERR1);
  // a new address phase only lands when our own data phase is completing
  assign w_acc = hsel & htrans[1] & hready & w_rdy;
  assign w_err = (hsize > 3'd2)
               | ((hsize == 3'd1) & haddr[0])
               | ((hsize == 3'd2) & (haddr[1:0] != 2'b00))
               | (haddr[CW+1:2] >= LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_off   <= '0;
      r_size  <= '0;
      r_write <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_acc) begin
        r_idx   <= haddr[IW+1:2];
        r_off   <= haddr[1:0];
        r_size  <= hsize[1:0];
        r_write <= hwrite;
      end
      r_cnt <= (r_state == S_WAIT) ? r_cnt + 4'd1 : 4'd0;
    end
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_WAIT:  if (r_cnt == WS_LAST) w_nxt = S_DATA;
      S_ERR1:  w_nxt = S_ERR2;
      default: begin
        if (!w_acc)                w_nxt = S_IDLE;
        else if (w_err)            w_nxt = S_ERR1;
        else if (WAIT_STATES > 0)  w_nxt = S_WAIT;
        else                       w_nxt = S_DATA;
      end
    endcase
  end

  assign hreadyout = w_rdy;
  assign hresp     = (r_state == S_ERR1) || (r_state == S_ERR2);
  assign hrdata    = (r_state == S_DATA && !r_write) ? r_mem[r_idx] : 32'h0;

  always_comb begin
    w_be = 4'b1111;
    case (r_size)
      2'd0:    w_be = 4'b0001 << r_off;
      2'd1:    w_be = r_off[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  // state is reset asynchronously, so a reset during the data phase blocks the write
  assign w_we = (r_state == S_DATA) && r_write;

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[r_idx][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end
endmodule

// File: doc/ahbl_sram_slave.md
Name: ahbl_sram_slave

Overview:
- AHB-Lite responder (subordinate) fronting a word-organised on-chip SRAM model.
- Terminates the transfers issued by the core-side AHB-Lite master bridges on the instruction and data ports.
- Supports byte, halfword and word transfers, programmable wait states, and a two-cycle ERROR response for illegal accesses.
- One instance per memory region on the interconnect.

Parameters:
- ADDR_WIDTH, 32, width of HADDR.
- MEM_WORDS, 1024, depth in 32-bit words; valid byte range is 0 to MEM_WORDS*4-1 (region offset; upper bits of HADDR above log2(MEM_WORDS*4) are ignored).
- WAIT_STATES, 0, number of HREADYOUT=0 cycles inserted in every OKAY data phase (0..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- hsel  in  1  slave select from decoder.
- haddr  in  ADDR_WIDTH  byte address (address phase).
- htrans  in  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- hwrite  in  1  1 = write.
- hsize  in  3  0 byte, 1 halfword, 2 word; others illegal.
- hburst  in  3  ignored (every beat is handled as a single transfer).
- hprot  in  4  ignored.
- hmastlock  in  1  ignored.
- hwdata  in  32  write data (data phase).
- hready  in  1  bus-level ready (mux of all HREADYOUTs).
- hreadyout  out  1  this slave's ready.
- hresp  out  1  0 OKAY, 1 ERROR.
- hrdata  out  32  read data.

Behaviour:
- Reset (asynchronous, immediate):
  - FSM to IDLE.
  - hreadyout=1, hresp=0, hrdata=0.
  - Wait counter=0.
  - Pending-phase registers cleared.
  - Memory contents not reset.
- Address phase acceptance:
  - Accepted when hsel & htrans[1] & hready at a rising edge.
  - On acceptance, register addr_q, write_q, size_q, and err_q.
  - BUSY/IDLE or hsel=0 with hready=1 produces no pending transfer. The next cycle is a zero-wait OKAY (hreadyout=1, hresp=0, hrdata=0).
- err_q is set for any of:
  - hsize > 2.
  - Halfword with haddr[0]=1.
  - Word with haddr[1:0]!=0.
  - Word index haddr[..2] >= MEM_WORDS.
- FSM states:
  - IDLE: no pending data phase; hreadyout=1, hresp=0. On accepted transfer: to ERR1 if err, else to WAIT if WAIT_STATES>0, else to DATA.
  - WAIT: hreadyout=0, hresp=0. Counter counts WAIT_STATES cycles, then goes to DATA.
  - DATA: hreadyout=1, hresp=0.
    - Read: hrdata = mem[addr_q] (full word, combinational from array; byte lanes per AHB little-endian, master extracts).
    - Write: at the end of this cycle, byte lanes enabled by size_q/addr_q[1:0] are written from hwdata (byte: lane addr[1:0]; half: lanes addr[1]*2 and addr[1]*2+1; word: all).
    - Next state per a new accepted transfer, as from IDLE, else IDLE.
  - ERR1: hreadyout=0, hresp=1. No memory access. Always goes to ERR2.
  - ERR2: hreadyout=1, hresp=1. A transfer accepted this edge is processed normally; a master that cancels drives IDLE, which returns to IDLE.
- Latency:
  - Read data is valid at 1+WAIT_STATES cycles after the address phase.
  - Back-to-back NONSEQs sustain one transfer per cycle at WAIT_STATES=0.
- Read-after-write:
  - A write commits at the end of its DATA cycle.
  - A read to the same word in the immediately following transfer returns the new data.
- hrdata is 0 outside read DATA cycles.
- hready=0 from another slave while this slave is IDLE means no acceptance; the address is held and sampled later.
- Reset mid-transfer: the pending write is dropped (no partial write), the FSM returns to IDLE, and outputs return to reset values.

Test Plan:
- Reset, then word write 0xDEADBEEF to addr 0x10 followed back-to-back by a read of 0x10, WAIT_STATES=0 -> write hreadyout=1 every cycle; read data phase hrdata=0xDEADBEEF, hresp=0.
- Byte write 0xAA to 0x13, halfword write 0x1234 to 0x10 on top of word 0x00000000, then read 0x10 -> hrdata=0xAA001234.
- WAIT_STATES=2, read 0x20 -> hreadyout=0 for exactly 2 data-phase cycles, then 1 with valid hrdata; the next address phase is held until the ready cycle.
- Word read at 0x02 (misaligned) -> cycle 1: hreadyout=0, hresp=1; cycle 2: hreadyout=1, hresp=1; memory unchanged. Repeat with hsize=3 and with addr 0x1000 (MEM_WORDS=1024) -> same ERROR pattern.
- hsel=1 with htrans=BUSY, then hsel=0 with htrans=NONSEQ -> hreadyout=1, hresp=0 throughout; no memory access.
- rst_n asserted during the WAIT state of a word write to 0x40 (WAIT_STATES=3) -> outputs at reset values immediately; a later read of 0x40 returns the prior contents.
